yarp_fetch_unit: RTL and testbench

YARP_FETCH_UNIT -- requirements
Module: yarp_fetch_unit

---
 rtl/yarp_pkg.sv | 12 +
 rtl/yarp_fetch_fifo.sv | 57 +++++
 rtl/yarp_fetch_unit.sv | 138 +++++++++++++
 tb/tb_yarp_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared types and constants for the YARP fetch front end.
package yarp_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    DROP  = 2'b10
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/yarp_fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with flush; flush beats push/pop.
module yarp_fetch_fifo
  import yarp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [PW:0]      count_r;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        mem_r[wptr_r] <= wdata;
        wptr_r        <= wptr_r + 1'b1;
      end
      if (pop) begin
        rptr_r <= rptr_r + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rptr_r];
  assign count = count_r;

endmodule

// File: rtl/yarp_fetch_unit.sv
// Instruction fetch unit: one outstanding I-cache request feeding a prefetch
// buffer toward decode, with redirect handling and a fetch-bubble counter.
module yarp_fetch_unit
  import yarp_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000,
  parameter int              DEPTH    = 4,
  parameter int              PERF_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     icache_req_o,
  output logic [XLEN-1:0]          icache_addr_o,
  input  logic                     icache_ready_i,
  input  logic                     icache_valid_i,
  input  logic [31:0]              icache_data_i,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  input  logic                     stall_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [XLEN-1:0]          instr_pc_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [PERF_W-1:0]        bubble_cnt_o
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e       state_r;
  logic [XLEN-1:0]    fetch_pc_r;
  logic [XLEN-1:0]    req_pc_r;
  logic [PERF_W-1:0]  bubble_r;

  logic [CW-1:0]      count_s;
  logic               empty_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic [XLEN-1:0]    redirect_pc_s;
  logic [XLEN+31:0]   wdata_s;
  logic [XLEN+31:0]   rdata_s;

  // Request/handshake decode; the request is gated by reset so nothing issues while held.
  always_comb begin
    empty_s       = (count_s == '0);
    icache_req_o  = reset_n && (state_r == FETCH) && (count_s < DEPTH_C) && !redirect_i;
    accept_s      = icache_req_o && icache_ready_i;
    push_s        = (state_r == WAIT) && icache_valid_i && !redirect_i;
    instr_valid_o = !empty_s && !stall_i;
    pop_s         = instr_valid_o && instr_ready_i;
    redirect_pc_s = redirect_pc_i & ALIGN_MASK;
    wdata_s       = {req_pc_r, icache_data_i};
    if (empty_s) begin
      instr_o    = INSTR_NOP;
      instr_pc_o = '0;
    end else begin
      instr_o    = rdata_s[31:0];
      instr_pc_o = rdata_s[XLEN+31:32];
    end
  end

  // Fetch sequencing: a response arriving in DROP, or together with a redirect, is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= FETCH;
      fetch_pc_r <= RESET_PC & ALIGN_MASK;
      req_pc_r   <= '0;
    end else begin
      case (state_r)
        FETCH: begin
          if (redirect_i) begin
            fetch_pc_r <= redirect_pc_s;
          end else if (accept_s) begin
            state_r    <= WAIT;
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + PC_STEP;
          end else begin
            state_r <= FETCH;
          end
        end
        WAIT: begin
          if (redirect_i) begin
            fetch_pc_r <= redirect_pc_s;
            state_r    <= icache_valid_i ? FETCH : DROP;
          end else if (icache_valid_i) begin
            state_r <= FETCH;
          end else begin
            state_r <= WAIT;
          end
        end
        DROP: begin
          if (redirect_i) begin
            fetch_pc_r <= redirect_pc_s;
          end
          state_r <= icache_valid_i ? FETCH : DROP;
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

  // Saturating count of cycles where decode wanted an instruction but none was buffered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_r <= '0;
    end else if (instr_ready_i && !stall_i && empty_s && !redirect_i && (bubble_r != '1)) begin
      bubble_r <= bubble_r + 1'b1;
    end else begin
      bubble_r <= bubble_r;
    end
  end

  yarp_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + 32)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (redirect_i),
    .wdata   (wdata_s),
    .rdata   (rdata_s),
    .count   (count_s)
  );

  assign icache_addr_o = fetch_pc_r;
  assign fifo_count_o  = count_s;
  assign bubble_cnt_o  = bubble_r;

endmodule

// File: tb/tb_yarp_fetch_unit.sv
// Self-checking bench for yarp_fetch_unit: I-cache model, scoreboard queue, directed sequences.
module tb_yarp_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          PERF_W   = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              icache_req_o;
  logic [XLEN-1:0]   icache_addr_o;
  logic              icache_ready_i;
  logic              icache_valid_i;
  logic [31:0]       icache_data_i;
  logic              redirect_i;
  logic [XLEN-1:0]   redirect_pc_i;
  logic              stall_i;
  logic              instr_valid_o;
  logic [31:0]       instr_o;
  logic [XLEN-1:0]   instr_pc_o;
  logic              instr_ready_i;
  logic [2:0]        fifo_count_o;
  logic [PERF_W-1:0] bubble_cnt_o;

  yarp_fetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_ready_i(icache_ready_i), .icache_valid_i(icache_valid_i),
    .icache_data_i(icache_data_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .fifo_count_o(fifo_count_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } item_t;
  typedef struct { logic [31:0] redir_pc; logic [31:0] exp_addr; } vec_t;

  item_t             sb_q[$];
  logic [31:0]       delivered[$];
  int                n_checks = 0;
  int                n_fail = 0;
  bit                outst, stale, ic_pend;
  int                ic_cnt, lat, acc_cnt;
  logic [31:0]       ic_addr, exp_fetch_pc, last_acc_addr;
  logic [PERF_W-1:0] exp_bub;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    outst        = 1'b0;
    stale        = 1'b0;
    sb_q.delete();
    exp_fetch_pc = RESET_PC;
    exp_bub      = '0;
  endtask

  // One clock: drive I-cache response, check outputs against the model, then advance the model.
  task automatic cycle();
    bit    resp, acc, pop_s, push_s, exp_req, exp_valid;
    item_t it;
    resp           = ic_pend && (ic_cnt == 0);
    icache_valid_i = resp;
    icache_data_i  = resp ? data_of(ic_addr) : 32'h0;
    #1;
    exp_req   = reset_n && !outst && (sb_q.size() < DEPTH) && !redirect_i;
    exp_valid = (sb_q.size() != 0) && !stall_i;
    chk("icache_req", 64'(icache_req_o), 64'(exp_req));
    if (exp_req) chk("icache_addr", 64'(icache_addr_o), 64'(exp_fetch_pc));
    chk("fifo_count", 64'(fifo_count_o), 64'(sb_q.size()));
    chk("instr_valid", 64'(instr_valid_o), 64'(exp_valid));
    chk("bubble_cnt", 64'(bubble_cnt_o), 64'(exp_bub));
    pop_s = exp_valid && instr_ready_i;
    if (pop_s) begin
      chk("instr_pc", 64'(instr_pc_o), 64'(sb_q[0].pc));
      chk("instr_data", 64'(instr_o), 64'(sb_q[0].data));
      delivered.push_back(instr_pc_o);
    end
    acc    = exp_req && icache_ready_i;
    push_s = resp && outst && !stale && !redirect_i;
    if (push_s) chk("push_not_full", 64'(sb_q.size() < DEPTH), 64'(1));
    if (instr_ready_i && !stall_i && (sb_q.size() == 0) && !redirect_i && (exp_bub != '1))
      exp_bub = exp_bub + 1'b1;
    @(posedge clk);
    if (resp) begin
      ic_pend = 1'b0;
      outst   = 1'b0;
      stale   = 1'b0;
    end
    if (redirect_i) begin
      sb_q.delete();
      exp_fetch_pc = redirect_pc_i & 32'hFFFF_FFFC;
      if (outst) stale = 1'b1;
    end else begin
      if (pop_s) void'(sb_q.pop_front());
      if (push_s) begin
        it.pc   = ic_addr;
        it.data = data_of(ic_addr);
        sb_q.push_back(it);
      end
    end
    if (acc) begin
      ic_pend       = 1'b1;
      ic_cnt        = lat - 1;
      ic_addr       = exp_fetch_pc;
      outst         = 1'b1;
      stale         = 1'b0;
      last_acc_addr = exp_fetch_pc;
      acc_cnt++;
      exp_fetch_pc  = exp_fetch_pc + 32'd4;
    end else if (ic_pend && !resp) begin
      ic_cnt--;
    end
    @(negedge clk);
    icache_valid_i = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget && (outst || sb_q.size() != 0); i++) cycle();
    chk("idle_timeout", 64'(outst || sb_q.size() != 0), 64'(0));
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] head_pc, addr0;
    logic [PERF_W-1:0] bub0;
    int          acc0;

    vecs[0] = '{32'h0000_2002, 32'h0000_2000};
    vecs[1] = '{32'h0000_3001, 32'h0000_3000};
    vecs[2] = '{32'h0000_0007, 32'h0000_0004};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[4] = '{32'h8000_0010, 32'h8000_0010};
    vecs[5] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC};

    reset_n = 1'b0; icache_ready_i = 1'b0; icache_valid_i = 1'b0; icache_data_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; stall_i = 1'b0; instr_ready_i = 1'b0;
    ic_pend = 1'b0; ic_cnt = 0; ic_addr = 32'h0; acc_cnt = 0; last_acc_addr = 32'h0; lat = 1;
    model_reset();
    #1;
    chk("rst_req", 64'(icache_req_o), 64'(0));
    chk("rst_valid", 64'(instr_valid_o), 64'(0));
    chk("rst_count", 64'(fifo_count_o), 64'(0));
    chk("rst_bubble", 64'(bubble_cnt_o), 64'(0));

    // Straight-line fetch with 1-cycle latency
    icache_ready_i = 1'b1; instr_ready_i = 1'b1; lat = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("first_req", 64'(icache_req_o), 64'(1));
    chk("first_addr", 64'(icache_addr_o), 64'(RESET_PC));
    delivered.delete();
    repeat (8) cycle();
    chk("seq_len_ok", 64'(delivered.size() >= 3), 64'(1));
    if (delivered.size() >= 3) begin
      chk("seq_pc0", 64'(delivered[0]), 64'h1000);
      chk("seq_pc1", 64'(delivered[1]), 64'h1004);
      chk("seq_pc2", 64'(delivered[2]), 64'h1008);
    end

    // Decode not ready: buffer fills, requests stop, drain order intact
    instr_ready_i = 1'b0;
    repeat (20) cycle();
    chk("full_count", 64'(fifo_count_o), 64'(4));
    chk("full_no_req", 64'(icache_req_o), 64'(0));
    icache_ready_i = 1'b0; instr_ready_i = 1'b1;
    delivered.delete();
    run_until_idle(20);
    chk("drain_pops", 64'(delivered.size()), 64'(4));
    for (int i = 0; i + 1 < delivered.size(); i++)
      chk("drain_consecutive", 64'(delivered[i+1]), 64'(delivered[i] + 32'd4));

    // Stall with full buffer
    icache_ready_i = 1'b1; instr_ready_i = 1'b0;
    for (int i = 0; i < 30 && sb_q.size() < DEPTH; i++) cycle();
    chk("stall_fill", 64'(fifo_count_o), 64'(4));
    head_pc = (sb_q.size() != 0) ? sb_q[0].pc : 32'hFFFF_FFFF;
    bub0 = bubble_cnt_o;
    stall_i = 1'b1; instr_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("stall_valid", 64'(instr_valid_o), 64'(0));
    end
    chk("stall_bubble", 64'(bubble_cnt_o), 64'(bub0));
    stall_i = 1'b0;
    #1;
    chk("unstall_valid", 64'(instr_valid_o), 64'(1));
    chk("unstall_pc", 64'(instr_pc_o), 64'(head_pc));
    icache_ready_i = 1'b0;
    run_until_idle(20);

    // Redirect to 0x2002 while waiting; response 3 cycles later discarded
    icache_ready_i = 1'b1; instr_ready_i = 1'b0; lat = 4;
    for (int i = 0; i < 30 && !(outst && sb_q.size() != 0); i++) cycle();
    chk("redir_setup", 64'(fifo_count_o != 3'd0), 64'(1));
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_2002;
    cycle();
    redirect_i = 1'b0;
    chk("redir_flush_count", 64'(fifo_count_o), 64'(0));
    instr_ready_i = 1'b1;
    acc0 = acc_cnt;
    for (int i = 0; i < 10 && acc_cnt == acc0; i++) cycle();
    chk("redir_next_addr", 64'(last_acc_addr), 64'h2000);
    lat = 1;
    icache_ready_i = 1'b0;
    run_until_idle(20);

    // Table: redirect alignment, then address wrap
    for (int v = 0; v < 6; v++) begin
      redirect_i = 1'b1; redirect_pc_i = vecs[v].redir_pc;
      cycle();
      redirect_i = 1'b0;
      #1;
      chk("redir_tbl_addr", 64'(icache_addr_o), 64'(vecs[v].exp_addr));
      chk("redir_tbl_req", 64'(icache_req_o), 64'(1));
    end
    icache_ready_i = 1'b1;
    cycle();
    chk("wrap_addr", 64'(icache_addr_o), 64'h0);
    acc0 = acc_cnt;
    for (int i = 0; i < 10 && acc_cnt == acc0; i++) cycle();
    chk("wrap_acc_addr", 64'(last_acc_addr), 64'h0);
    icache_ready_i = 1'b0;
    run_until_idle(20);

    // I-cache never ready: bubble counter saturates, address held
    addr0 = icache_addr_o;
    repeat ((1 << PERF_W) + 5) cycle();
    chk("bubble_sat", 64'(bubble_cnt_o), 64'hFFFF);
    chk("addr_stable", 64'(icache_addr_o), 64'(addr0));

    // Reset while waiting; late response ignored
    icache_ready_i = 1'b1; lat = 3;
    for (int i = 0; i < 10 && !outst; i++) cycle();
    chk("rst_wait_setup", 64'(outst), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", 64'(icache_req_o), 64'(0));
    chk("arst_valid", 64'(instr_valid_o), 64'(0));
    chk("arst_count", 64'(fifo_count_o), 64'(0));
    chk("arst_bubble", 64'(bubble_cnt_o), 64'(0));
    model_reset();
    icache_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10 && ic_pend; i++) cycle();
    cycle();
    chk("late_resp_count", 64'(fifo_count_o), 64'(0));
    chk("late_resp_req", 64'(icache_req_o), 64'(1));
    chk("late_resp_addr", 64'(icache_addr_o), 64'(RESET_PC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
